serial_add_sequencer: RTL and testbench
=======================================

# serial_add_sequencer

Bit-serial adder/subtractor controller that time-shares a single 1-bit full-adder cell across all bit positions of a WIDTH-bit operation. The cell is built from two HalfAdder instances plus an OR for carry. The block captures operands on a START handshake and sequences one bit per clock, LSB first, through the shared cell. It then presents the WIDTH-bit result and carry with a one-cycle DONE pulse. It sits between a simple command source (switches, test FSM) and the shared arithmetic cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset; clears all state.
- START  input  1  request; sampled on CLK rising edge; accepted only in IDLE or FIN.
- SUB  input  1  0 = A+B, 1 = A−B; captured with the operands on accept.
- A  input  WIDTH  operand A; captured on accept.
- B  input  WIDTH  operand B; captured on accept.
- BUSY  output  1  high while an operation is in progress (RUN).
- DONE  output  1  one-cycle pulse; SUM/COUT valid from this cycle.
- SUM  output  WIDTH  result, mod 2^WIDTH; held until the next completion.
- COUT  output  1  carry out of the MSB. For SUB it is 1 when there is no borrow (A ≥ B, unsigned).

## Operation
- States: IDLE, RUN, FIN. Reset state is IDLE.
- IDLE: START=1 → RUN. On that edge:
  - load shift register ra ← A;
  - load shift register rb ← (SUB ? ~B : B);
  - carry register c ← SUB;
  - bit counter ← 0.
- RUN, each edge:
  - the shared cell computes s = ra[0]^rb[0]^c and co = (ra[0]&rb[0]) | (c&(ra[0]^rb[0]));
  - ra and rb shift right by one;
  - s shifts into the MSB of the internal sum shift register;
  - c ← co; counter increments.
- RUN → FIN on the edge that processes bit WIDTH−1 (counter = WIDTH−1). On that same edge:
  - SUM ← completed sum register, with the final bit included;
  - COUT ← co.
- FIN: DONE=1 for exactly this cycle.
  - START=1 → RUN with new operands (back-to-back accept).
  - Otherwise → IDLE.
- START in RUN is ignored. It is not queued.
- A, B and SUB are don't-care except on the accepting edge.
- SUM and COUT change only on the RUN→FIN edge or on reset.
- Arithmetic is unsigned, modulo 2^WIDTH. The counter is $clog2(WIDTH) bits wide and never wraps within an operation.
- Reset mid-operation: RST at any time forces IDLE immediately, with all outputs and internal registers at 0. The aborted operation produces no DONE. SUM/COUT read 0, not stale data.

## Timing
- Reset values: BUSY=0, DONE=0, SUM=0, COUT=0, state IDLE.
- Accept on edge E0 → BUSY=1 from E0 through E_WIDTH.
  - At E_WIDTH: BUSY=0, DONE=1, SUM/COUT updated.
  - At E_WIDTH+1: DONE=0.
- Result latency is WIDTH clocks from the accepting edge.
- Throughput is one operation per WIDTH+1 clocks. This includes back-to-back operation: START held high in FIN gives a new accept at E_WIDTH+1.
- BUSY and DONE are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then WIDTH=8, A=0x3C, B=0x5A, SUB=0, 1-cycle START → BUSY high for 8 cycles, then DONE pulse with SUM=0x96, COUT=0; DONE exactly 8 edges after accept.
- A=0xFF, B=0x01, SUB=0 → SUM=0x00, COUT=1 (full carry ripple).
- SUB=1: A=0x10, B=0x01 → SUM=0x0F, COUT=1. Then A=0x01, B=0x02 → SUM=0xFF, COUT=0.
- During RUN, pulse START with A=0xAA, B=0x55, and change the A/B inputs mid-operation → both ignored; result is that of the original operands; exactly one DONE.
- START held high continuously with A=0x01, B=0x01 → DONE pulse every 9 cycles, SUM=0x02 each time; BUSY low only in the DONE cycles.
- Mid-operation reset: assert RST for 1 cycle after 3 bits of 0x3C+0x5A → all outputs 0 immediately, no DONE; next operation 0x12+0x34 → SUM=0x46, COUT=0.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor: one shared full-adder cell (two half adders + OR)
// processes WIDTH bits LSB first, then presents SUM/COUT with a one-cycle DONE.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-2:0] sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             p;
  logic             g1;
  logic             s;
  logic             g2;
  logic             co;
  logic [WIDTH-1:0] sum_full;

  half_adder ha0 (.a(ra[0]), .b(rb[0]), .s(p), .c(g1));
  half_adder ha1 (.a(p),     .b(c),     .s(s), .c(g2));
  assign co = g1 | g2;

  // Only the upper WIDTH-1 sum bits are stored; the current cell output
  // completes the word, so the final edge can load SUM directly.
  assign sum_full = {s, sr};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      sr    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      SUM   <= '0;
      COUT  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          DONE <= 1'b0;
          if (START) begin
            ra    <= A;
            rb    <= SUB ? ~B : B;
            c     <= SUB;
            sr    <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          sr  <= sum_full[WIDTH-1:1];
          c   <= co;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            SUM   <= sum_full;
            COUT  <= co;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench: a model tracks accepts and pushes expected results; a
// monitor compares DUT outputs one time unit after every clock edge.
module tb_serial_add_sequencer;
  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         SUB;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         COUT;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int unsigned  due;
  } exp_t;

  exp_t         q[$];
  int unsigned  cyc = 0;
  int unsigned  next_free = 0;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: a new operation is accepted once the previous one has had its
  // WIDTH processing edges plus the DONE cycle; result is plain arithmetic.
  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      q.delete();
      next_free = 0;
    end else if (START && cyc >= next_free) begin
      exp_t e;
      longint unsigned av, bv, r;
      av = longint'(A);
      bv = longint'(B);
      if (SUB) begin
        r      = (av + (longint'(1) << W) - bv) % (longint'(1) << W);
        e.cout = (av >= bv);
      end else begin
        r      = av + bv;
        e.cout = r[W];
      end
      e.sum = r[W-1:0];
      e.due = cyc + W;
      q.push_back(e);
      next_free = cyc + W + 1;
    end
  end

  always @(posedge RST) begin
    q.delete();
    next_free = 0;
    hold_sum  = '0;
    hold_cout = 1'b0;
    #1;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_sum",  32'(SUM),  0);
    chk("rst_cout", 32'(COUT), 0);
  end

  always @(posedge CLK) begin
    #1;
    if (RST) begin
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_done", 32'(DONE), 0);
      chk("rst_sum",  32'(SUM),  0);
      chk("rst_cout", 32'(COUT), 0);
    end else begin
      chk("busy_done_excl", 32'(BUSY & DONE), 0);
      chk("busy", 32'(BUSY), 32'(q.size() > 0 && cyc < q[0].due));
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("done", 32'(DONE), 1);
        hold_sum  = q[0].sum;
        hold_cout = q[0].cout;
        void'(q.pop_front());
      end else begin
        chk("no_done", 32'(DONE), 0);
      end
      chk("sum",  32'(SUM),  32'(hold_sum));
      chk("cout", 32'(COUT), 32'(hold_cout));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge CLK);
    START = 1'b1; A = a; B = b; SUB = s;
    @(negedge CLK);
    START = 1'b0; A = W'($urandom); B = W'($urandom); SUB = 1'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
    idle(2);
    RST = 1'b0;
    idle(2);

    issue(8'h3C, 8'h5A, 1'b0); idle(W + 1);
    issue(8'hFF, 8'h01, 1'b0); idle(W + 1);
    issue(8'h10, 8'h01, 1'b1); idle(W + 1);
    issue(8'h01, 8'h02, 1'b1); idle(W + 1);

    // START and operand changes while running must be ignored
    issue(8'h21, 8'h13, 1'b0);
    idle(3);
    START = 1'b1; A = 8'hAA; B = 8'h55;
    idle(1);
    START = 1'b0; A = 8'h77; B = 8'h99;
    idle(W + 2);

    // Back-to-back accepts with START held high
    @(negedge CLK);
    START = 1'b1; A = 8'h01; B = 8'h01; SUB = 1'b0;
    idle(4 * (W + 1));
    START = 1'b0;
    idle(W + 2);

    // Reset after three bits have been processed
    issue(8'h3C, 8'h5A, 1'b0);
    idle(3);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    issue(8'h12, 8'h34, 1'b0); idle(W + 2);

    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      START = ($urandom_range(3) == 0);
      A     = W'($urandom);
      B     = W'($urandom);
      SUB   = 1'($urandom);
      RST   = ($urandom_range(199) == 0);
    end
    @(negedge CLK);
    START = 1'b0; RST = 1'b0;
    idle(2 * W + 2);

    chk("drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
